// File: rtl/data_ram_mmio.sv
// data_ram_mmio -- data-side memory for the CPU MEM stage (ram_* bus).
//
// Word-organised RAM with byte-lane writes and combinational read data.
// Optional MMIO window (build with DATA_RAM_MMIO_EN defined) selected by
// addr_i[31:28] == MMIO_TAG:
//   addr_i[3:2] = 0 CYCLE  : free-running counter, writable
//   addr_i[3:2] = 1 CMP    : compare value
//   addr_i[3:2] = 2 STATUS : bit0 MATCH (write-1-to-clear, set wins)
//   addr_i[3:2] = 3 TOHOST : write sets done_o, read returns tohost_o
// Without DATA_RAM_MMIO_EN every address goes to RAM and irq_o/done_o/tohost_o are 0.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset (MMIO state only)
//   ce_i, we_i       access enable, 1 = write
//   addr_i[31:0]     byte address (bits 1:0 ignored)
//   sel_i[3:0]       byte-lane enables, sel_i[3] -> data[31:24]
//   data_i[31:0]     write data
//   data_o[31:0]     read data, combinational; 0 when not reading or in reset
//   irq_o            MATCH flag level
//   done_o           sticky TOHOST-written flag
//   tohost_o[31:0]   last TOHOST value
module data_ram_mmio #(
  parameter int         RAM_WORDS_LOG2 = 10,
  parameter logic [3:0] MMIO_TAG       = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq_o,
  output logic        done_o,
  output logic [31:0] tohost_o
);

  localparam int RAM_DEPTH = 1 << RAM_WORDS_LOG2;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] lane_mask;
    lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old_w & ~lane_mask) | (new_w & lane_mask);
  endfunction

  logic [31:0]               ram [RAM_DEPTH];
  logic [RAM_WORDS_LOG2-1:0] ram_idx;
  logic [31:0]               ram_rd;
  logic [31:0]               mmio_rd;
  logic                      mmio_hit;
  logic                      wr_req;
  logic                      ram_wr;
  logic                      unused_ok;

  // Upper address bits alias; MMIO_TAG is unused in the RAM-only build.
  assign unused_ok = ^{addr_i, MMIO_TAG};

  assign ram_idx = addr_i[RAM_WORDS_LOG2+1:2];
  assign ram_rd  = ram[ram_idx];
  // A write with no lanes selected is a no-op everywhere; writes during reset are dropped.
  assign wr_req  = ce_i & we_i & ~rst & (|sel_i);
  assign ram_wr  = wr_req & ~mmio_hit;

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_i[b]) ram[ram_idx][8*b +: 8] <= data_i[8*b +: 8];
      end
    end
  end

`ifdef DATA_RAM_MMIO_EN
  logic [31:0] cycle_q;
  logic [31:0] cmp_q;
  logic [31:0] tohost_q;
  logic        match_q;
  logic        done_q;
  logic [1:0]  reg_sel;
  logic        wr_cycle;
  logic        wr_cmp;
  logic        wr_tohost;
  logic        clr_match;

  assign mmio_hit  = (addr_i[31:28] == MMIO_TAG);
  assign reg_sel   = addr_i[3:2];
  assign wr_cycle  = wr_req & mmio_hit & (reg_sel == 2'd0);
  assign wr_cmp    = wr_req & mmio_hit & (reg_sel == 2'd1);
  assign clr_match = wr_req & mmio_hit & (reg_sel == 2'd2) & sel_i[0] & data_i[0];
  assign wr_tohost = wr_req & mmio_hit & (reg_sel == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q  <= 32'h0;
      cmp_q    <= 32'hFFFF_FFFF;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
      tohost_q <= 32'h0;
    end else begin
      // A write replaces the count for this cycle instead of incrementing it.
      cycle_q <= wr_cycle ? lane_merge(cycle_q, data_i, sel_i) : cycle_q + 32'd1;
      if (wr_cmp) cmp_q <= lane_merge(cmp_q, data_i, sel_i);
      // Compare uses the registered values; a simultaneous set beats the clear.
      if (cycle_q == cmp_q)  match_q <= 1'b1;
      else if (clr_match)    match_q <= 1'b0;
      if (wr_tohost) begin
        tohost_q <= lane_merge(tohost_q, data_i, sel_i);
        done_q   <= 1'b1;
      end
    end
  end

  always_comb begin
    mmio_rd = 32'h0;
    case (reg_sel)
      2'd0:    mmio_rd = cycle_q;
      2'd1:    mmio_rd = cmp_q;
      2'd2:    mmio_rd = {31'h0, match_q};
      default: mmio_rd = tohost_q;
    endcase
  end

  assign irq_o    = match_q;
  assign done_o   = done_q;
  assign tohost_o = tohost_q;
`else
  assign mmio_hit = 1'b0;
  assign mmio_rd  = 32'h0;
  assign irq_o    = 1'b0;
  assign done_o   = 1'b0;
  assign tohost_o = 32'h0;
`endif

  always_comb begin
    data_o = 32'h0;
    if (!rst && ce_i && !we_i) data_o = mmio_hit ? mmio_rd : ram_rd;
  end

endmodule

// File: tb/tb_data_ram_mmio.sv
// Self-checking bench for data_ram_mmio: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_data_ram_mmio;
  localparam int LG = 10;
`ifdef DATA_RAM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i, we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        irq_o, done_o;
  logic [31:0] tohost_o;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  data_ram_mmio #(.RAM_WORDS_LOG2(LG), .MMIO_TAG(4'hF)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .sel_i(sel_i), .data_i(data_i), .data_o(data_o), .irq_o(irq_o),
    .done_o(done_o), .tohost_o(tohost_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [1 << LG];
  bit   [3:0]  m_val [1 << LG];
  logic [31:0] m_cyc, m_cmp, m_tohost;
  logic        m_match, m_done;
  logic [31:0] t_cyc, t_cmp;
  int          w;

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                      input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cyc = 32'h0; m_cmp = 32'hFFFF_FFFF; m_match = 1'b0;
      m_done = 1'b0; m_tohost = 32'h0;
    end else begin
      t_cyc = m_cyc;
      t_cmp = m_cmp;
      if (MMIO_EN) begin
        m_cyc = t_cyc + 1;
        if (t_cyc == t_cmp) m_match = 1'b1;
        else if (ce_i && we_i && addr_i[31:28] == 4'hF && addr_i[3:2] == 2'd2 &&
                 sel_i[0] && data_i[0]) m_match = 1'b0;
      end
      if (ce_i && we_i && sel_i != 4'b0) begin
        if (MMIO_EN && addr_i[31:28] == 4'hF) begin
          case (addr_i[3:2])
            2'd0: m_cyc = mrg(t_cyc, data_i, sel_i);
            2'd1: m_cmp = mrg(t_cmp, data_i, sel_i);
            2'd3: begin m_tohost = mrg(m_tohost, data_i, sel_i); m_done = 1'b1; end
            default: ;
          endcase
        end else begin
          w = int'(addr_i[LG+1:2]);
          m_mem[w] = mrg(m_mem[w], data_i, sel_i);
          m_val[w] = m_val[w] | sel_i;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [31:0] e_data, e_mask;
  int          rw;
  always @(negedge clk) begin
    if (chk_on) begin
      e_data = 32'h0;
      e_mask = 32'hFFFF_FFFF;
      if (!rst && ce_i && !we_i) begin
        if (MMIO_EN && addr_i[31:28] == 4'hF) begin
          case (addr_i[3:2])
            2'd0: e_data = m_cyc;
            2'd1: e_data = m_cmp;
            2'd2: e_data = {31'h0, m_match};
            default: e_data = m_tohost;
          endcase
        end else begin
          rw = int'(addr_i[LG+1:2]);
          e_mask = {{8{m_val[rw][3]}}, {8{m_val[rw][2]}}, {8{m_val[rw][1]}}, {8{m_val[rw][0]}}};
          e_data = m_mem[rw] & e_mask;
        end
      end
      if (e_mask != 32'h0) chk("data_o", data_o & e_mask, e_data);
      chk("irq_o", {31'h0, irq_o}, {31'h0, m_match});
      chk("done_o", {31'h0, done_o}, {31'h0, m_done});
      chk("tohost_o", tohost_o, m_tohost);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic ce, input logic we, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d);
    ce_i = ce; we_i = we; addr_i = a; sel_i = s; data_i = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ra;

  initial begin
    rst = 1'b1;
    drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    chk_on = 1'b1;
    drv(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    #1;
    chk("rst_data", data_o, 32'h0);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_tohost", tohost_o, 32'h0);
    step();
    rst = 1'b0;

    // T1
    drv(1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF); step();
    drv(1'b1, 1'b0, 32'h100, 4'hF, 32'h0); #1;
    chk("t1_read", data_o, 32'hDEADBEEF);
    // T2
    drv(1'b1, 1'b1, 32'h100, 4'b0101, 32'h11223344); step();
    drv(1'b1, 1'b0, 32'h100, 4'hF, 32'h0); #1;
    chk("t2_lanes", data_o, 32'hDE22BE44);
    drv(1'b1, 1'b1, 32'h100, 4'b0000, 32'hFFFFFFFF); step();
    drv(1'b1, 1'b0, 32'h100, 4'hF, 32'h0); #1;
    chk("t2_sel0", data_o, 32'hDE22BE44);
    // T3
    drv(1'b0, 1'b0, 32'h100, 4'hF, 32'h0); #1;
    chk("t3_ce0", data_o, 32'h0);
    drv(1'b1, 1'b1, 32'h104, 4'hF, 32'hCAFEF00D); #1;
    chk("t3_we1", data_o, 32'h0);
    step();
    drv(1'b1, 1'b0, 32'h104 | (32'h1 << (LG + 2)), 4'hF, 32'h0); #1;
    chk("t3_alias", data_o, 32'hCAFEF00D);

    if (MMIO_EN) begin
      // T4
      rst = 1'b1; drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); step(); rst = 1'b0;
      drv(1'b1, 1'b1, 32'hF000_0004, 4'hF, 32'd5); step();
      drv(1'b1, 1'b0, 32'hF000_0000, 4'hF, 32'h0);
      step(); step(); step(); step();
      chk("t4_cyc5", data_o, 32'd5);
      chk("t4_irq_lo", {31'h0, irq_o}, 32'h0);
      step();
      chk("t4_cyc6", data_o, 32'd6);
      chk("t4_irq_hi", {31'h0, irq_o}, 32'h1);
      drv(1'b1, 1'b1, 32'hF000_0008, 4'b0001, 32'h1); step();
      drv(1'b1, 1'b0, 32'hF000_0008, 4'hF, 32'h0); #1;
      chk("t4_w1c", {31'h0, irq_o}, 32'h0);
      chk("t4_status", data_o, 32'h0);
      drv(1'b1, 1'b1, 32'hF000_0000, 4'hF, 32'hFFFF_FFFE); step();
      drv(1'b1, 1'b0, 32'hF000_0000, 4'hF, 32'h0); #1;
      chk("t4_wr_cyc", data_o, 32'hFFFF_FFFE);
      step(); chk("t4_cyc_max", data_o, 32'hFFFF_FFFF);
      step(); chk("t4_wrap", data_o, 32'h0);
      // T5
      drv(1'b1, 1'b1, 32'hF000_0004, 4'hF, 32'd100); step();
      drv(1'b1, 1'b1, 32'hF000_0000, 4'hF, 32'd100); step();
      drv(1'b1, 1'b1, 32'hF000_0008, 4'b0001, 32'h1); step();
      drv(1'b1, 1'b0, 32'hF000_0008, 4'hF, 32'h0); #1;
      chk("t5_set_wins", {31'h0, irq_o}, 32'h1);
      chk("t5_status", data_o, 32'h1);
      rst = 1'b1;
      drv(1'b1, 1'b0, 32'hF000_0000, 4'hF, 32'h0); #1;
      chk("t5_rst_data", data_o, 32'h0);
      step(); rst = 1'b0; #1;
      chk("t5_rst_cyc", data_o, 32'h0);
      chk("t5_rst_irq", {31'h0, irq_o}, 32'h0);
      step(); chk("t5_resume", data_o, 32'h1);
      // T6
      drv(1'b1, 1'b1, 32'hF000_000C, 4'hF, 32'h1); step();
      drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
      chk("t6_done", {31'h0, done_o}, 32'h1);
      chk("t6_tohost", tohost_o, 32'h1);
      step(); step(); step();
      chk("t6_sticky", {31'h0, done_o}, 32'h1);
    end else begin
      // T6 without the MMIO window: the write is ordinary RAM
      drv(1'b1, 1'b1, 32'hF000_000C, 4'hF, 32'h1); step();
      drv(1'b1, 1'b0, 32'hF000_000C, 4'hF, 32'h0); #1;
      chk("t6_ram", data_o, 32'h1);
      chk("t6_no_done", {31'h0, done_o}, 32'h0);
      chk("t6_no_tohost", tohost_o, 32'h0);
    end

    // Randomized run; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(63) == 0);
      ra = $urandom;
      ra[11:6] = 6'h0;
      if ($urandom_range(2) == 0) ra[31:28] = 4'hF;
      else if (ra[31:28] == 4'hF) ra[31:28] = 4'h0;
      drv($urandom_range(3) != 0, $urandom_range(1) == 1, ra, 4'($urandom),
          ($urandom_range(3) == 0) ? 32'($urandom_range(7)) : $urandom);
      step();
    end
    rst = 1'b0;
    drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
